// File: rtl/flex_unpacker.sv
// Word-to-chunk unloader: accepts one NUM_BITS word and emits it as CHUNK_BITS chunks.
// Define FLEX_UNPACK_MSB_FIRST_EN to emit the most-significant chunk first (LSB-first otherwise).
module flex_unpacker #(
    parameter int NUM_BITS   = 32,
    parameter int CHUNK_BITS = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [NUM_BITS-1:0]   in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CHUNK_BITS-1:0] out_data,
    output logic                  out_last,
    output logic                  busy
);

    localparam int NUM_CHUNKS = NUM_BITS / CHUNK_BITS;
    localparam int CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_CHUNKS - 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

    logic [0:0]          state_r;
    logic [0:0]          state_s;
    logic [NUM_BITS-1:0] shift_r;
    logic [NUM_BITS-1:0] shift_s;
    logic [CNT_W-1:0]    cnt_r;
    logic [CNT_W-1:0]    cnt_s;
    logic                last_s;
    logic                in_xfer_s;
    logic                out_xfer_s;

    assign busy      = (state_r == SEND);
    assign out_valid = (state_r == SEND);
    assign last_s    = (state_r == SEND) && (cnt_r == LAST_CNT);
    assign out_last  = last_s;
    // A new word may enter while idle or in the same cycle the final chunk leaves.
    assign in_ready  = (state_r == IDLE) || (out_ready && last_s);
    assign in_xfer_s  = in_valid && in_ready;
    assign out_xfer_s = out_valid && out_ready;

`ifdef FLEX_UNPACK_MSB_FIRST_EN
    assign out_data = shift_r[NUM_BITS-1 -: CHUNK_BITS];
`else
    assign out_data = shift_r[CHUNK_BITS-1:0];
`endif

    // Next-state, shift-register and chunk-counter decode.
    always_comb begin
        state_s = state_r;
        shift_s = shift_r;
        cnt_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (in_xfer_s) begin
                    state_s = SEND;
                    shift_s = in_data;
                    cnt_s   = {CNT_W{1'b0}};
                end else begin
                    state_s = IDLE;
                end
            end
            SEND: begin
                if (out_xfer_s) begin
                    if (!last_s) begin
`ifdef FLEX_UNPACK_MSB_FIRST_EN
                        shift_s = shift_r << CHUNK_BITS;
`else
                        shift_s = shift_r >> CHUNK_BITS;
`endif
                        cnt_s   = cnt_r + CNT_W'(1);
                    end else if (in_xfer_s) begin
                        shift_s = in_data;
                        cnt_s   = {CNT_W{1'b0}};
                    end else begin
                        // Clear leftovers so an idle block presents zero data.
                        state_s = IDLE;
                        shift_s = {NUM_BITS{1'b0}};
                        cnt_s   = {CNT_W{1'b0}};
                    end
                end else begin
                    state_s = SEND;
                end
            end
            default: begin
                state_s = IDLE;
                shift_s = {NUM_BITS{1'b0}};
                cnt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State, shift-register and counter storage; reset discards any partial word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            shift_r <= {NUM_BITS{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_s;
            shift_r <= shift_s;
            cnt_r   <= cnt_s;
        end
    end

endmodule

// File: tb/tb_flex_unpacker.sv
// Directed self-checking bench for flex_unpacker: 32/8 instance and a single-chunk 8/8 instance.
module tb_flex_unpacker;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_last;
    logic        busy;

    logic        in_valid1;
    logic        in_ready1;
    logic [7:0]  in_data1;
    logic        out_valid1;
    logic        out_ready1;
    logic [7:0]  out_data1;
    logic        out_last1;
    logic        busy1;

    int n_checks = 0;
    int n_fail   = 0;

    flex_unpacker #(.NUM_BITS(32), .CHUNK_BITS(8)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy)
    );

    flex_unpacker #(.NUM_BITS(8), .CHUNK_BITS(8)) u_dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
        .out_last(out_last1), .busy(busy1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Chunk k of a word in emission order for the build under test.
    function automatic logic [7:0] chunk_of(input logic [31:0] w, input int k);
`ifdef FLEX_UNPACK_MSB_FIRST_EN
        return w[31 - 8*k -: 8];
`else
        return w[8*k +: 8];
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check_out(input string tag, input logic [7:0] d, input logic l, input logic r);
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_data"}, {24'd0, out_data}, {24'd0, d});
        check({tag, "_last"}, {31'd0, out_last}, {31'd0, l});
        check({tag, "_in_ready"}, {31'd0, in_ready}, {31'd0, r});
        check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_last"}, {31'd0, out_last}, 32'd0);
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        logic [31:0] w;
        rst = 1'b1;
        in_valid = 1'b1;
        in_data = 32'h12345678;
        out_ready = 1'b0;
        in_valid1 = 1'b0;
        in_data1 = 8'h00;
        out_ready1 = 1'b0;

        // Reset state, with in_valid asserted during reset
        tick();
        tick();
        check_idle("rst");
        check("rst_data", {24'd0, out_data}, 32'd0);
        check("rst1_valid", {31'd0, out_valid1}, 32'd0);
        check("rst1_in_ready", {31'd0, in_ready1}, 32'd1);
        in_valid = 1'b0;
        rst = 1'b0;
        tick();
        settle();
        check_idle("post_rst");

        // Single word
        w = 32'hAABBCCDD;
        tick();
        in_valid = 1'b1; in_data = w; out_ready = 1'b1;
        settle();
        check("t1_accept", {31'd0, in_ready}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            tick();
            in_valid = 1'b0;
            settle();
            check_out("t1", chunk_of(w, k), (k == 3), (k == 3));
        end
        tick();
        settle();
        check_idle("t1_end");

        // Back-to-back words, second held valid while the first drains
        tick();
        in_valid = 1'b1; in_data = 32'h03020100;
        settle();
        for (int k = 0; k < 8; k++) begin
            tick();
            if (k == 0) in_data = 32'h07060504;
            if (k == 4) in_valid = 1'b0;
            settle();
            w = (k < 4) ? 32'h03020100 : 32'h07060504;
            check_out("t2", chunk_of(w, k % 4), (k % 4 == 3), (k % 4 == 3));
        end
        tick();
        settle();
        check_idle("t2_end");

        // Stall on the third chunk while a foreign word is offered
        w = 32'hAABBCCDD;
        tick();
        in_valid = 1'b1; in_data = w;
        settle();
        tick();
        in_valid = 1'b0;
        settle();
        check_out("t3_c0", chunk_of(w, 0), 1'b0, 1'b0);
        tick();
        settle();
        check_out("t3_c1", chunk_of(w, 1), 1'b0, 1'b0);
        tick();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h11111111;
        settle();
        check_out("t3_stall", chunk_of(w, 2), 1'b0, 1'b0);
        for (int s = 0; s < 2; s++) begin
            tick();
            settle();
            check_out("t3_hold", chunk_of(w, 2), 1'b0, 1'b0);
        end
        tick();
        out_ready = 1'b1; in_valid = 1'b0;
        settle();
        check_out("t3_resume", chunk_of(w, 2), 1'b0, 1'b0);
        tick();
        settle();
        check_out("t3_c3", chunk_of(w, 3), 1'b1, 1'b1);
        tick();
        settle();
        check_idle("t3_end");

        // Reset in the middle of a word
        w = 32'h11223344;
        tick();
        in_valid = 1'b1; in_data = w;
        settle();
        for (int k = 0; k < 3; k++) begin
            tick();
            in_valid = 1'b0;
            settle();
            check_out("t4_pre", chunk_of(w, k), 1'b0, 1'b0);
        end
        #1;
        rst = 1'b1;
        #1;
        check_idle("t4_async");
        check("t4_async_data", {24'd0, out_data}, 32'd0);
        in_valid = 1'b1; in_data = 32'h55667788;
        tick();
        settle();
        check_idle("t4_in_rst");
        rst = 1'b0;
        w = 32'h55667788;
        for (int k = 0; k < 4; k++) begin
            tick();
            in_valid = 1'b0;
            settle();
            check_out("t4_new", chunk_of(w, k), (k == 3), (k == 3));
        end
        tick();
        settle();
        check_idle("t4_end");

        // Single-chunk instance acts as a full-throughput register slice
        tick();
        in_valid1 = 1'b1; in_data1 = 8'h01; out_ready1 = 1'b1;
        settle();
        check("t5_accept", {31'd0, in_ready1}, 32'd1);
        check("t5_lat", {31'd0, out_valid1}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            if (k < 2) in_data1 = 8'(k + 2);
            else in_valid1 = 1'b0;
            settle();
            check("t5_valid", {31'd0, out_valid1}, 32'd1);
            check("t5_data", {24'd0, out_data1}, 32'(k + 1));
            check("t5_last", {31'd0, out_last1}, 32'd1);
            check("t5_in_ready", {31'd0, in_ready1}, 32'd1);
        end
        tick();
        settle();
        check("t5_end_valid", {31'd0, out_valid1}, 32'd0);
        check("t5_end_busy", {31'd0, busy1}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
